// File: rtl/compliment2_pkg.sv
// Shared constants for the chunked two's-complement unit: operation modes and FSM encoding.
package compliment2_pkg;

  localparam logic [1:0] MODE_PASS  = 2'd0;
  localparam logic [1:0] MODE_NEG   = 2'd1;
  localparam logic [1:0] MODE_ABS   = 2'd2;
  localparam logic [1:0] MODE_SM2TC = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int unsigned num_chunks(input int unsigned width, input int unsigned chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/compliment2_slice.sv
// One CHUNK-bit step of a conditional one's-complement followed by a carry-in increment.
module compliment2_slice #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic             inv,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] sum;

  assign sum       = {1'b0, a ^ {CHUNK{inv}}} + {{CHUNK{1'b0}}, cin};
  assign {cout, s} = sum;

endmodule

// File: rtl/compliment2_chunked.sv
// Multi-cycle two's-complement unit (pass/negate/abs/sign-magnitude convert) that ripples a
// carry through a single shared slice, CHUNK bits per cycle, behind valid/ready handshakes.
module compliment2_chunked
  import compliment2_pkg::*;
#(
  parameter int unsigned WIDTH = 25,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned NCH  = num_chunks(WIDTH, CHUNK);
  localparam int unsigned IDXW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             inv_q, inv_d;
  logic             carry_q, carry_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_zero_q, out_zero_d;

  logic [WIDTH-1:0] acc_op;
  logic             acc_inv;
  logic [CHUNK-1:0] slice_a, slice_s;
  logic             slice_cout;
  logic             last;

  // Operand conditioning at the accept edge.
  always_comb begin
    acc_op  = in_data;
    acc_inv = 1'b0;
    case (in_mode)
      MODE_NEG: acc_inv = 1'b1;
      MODE_ABS: acc_inv = in_data[WIDTH-1];
      MODE_SM2TC: begin
        acc_inv = in_data[WIDTH-1];
        acc_op  = {1'b0, in_data[WIDTH-2:0]};
      end
      default: acc_inv = 1'b0;
    endcase
  end

  // Bits past WIDTH in the last chunk read as zero; their results are dropped.
  always_comb begin
    slice_a = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (idx_q == IDXW'(b / CHUNK)) slice_a[b % CHUNK] = op_q[b];
    end
  end

  compliment2_slice #(
    .CHUNK(CHUNK)
  ) u_slice (
    .a   (slice_a),
    .inv (inv_q),
    .cin (carry_q),
    .s   (slice_s),
    .cout(slice_cout)
  );

  assign last = (idx_q == IDXW'(NCH - 1));

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    work_d     = work_q;
    inv_d      = inv_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    ovf_pend_d = ovf_pend_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    out_zero_d = out_zero_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d       = acc_op;
          inv_d      = acc_inv;
          carry_d    = acc_inv;
          idx_d      = '0;
          ovf_pend_d = acc_inv & acc_op[WIDTH-1] & ~|acc_op[WIDTH-2:0];
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int b = 0; b < WIDTH; b++) begin
          if (idx_q == IDXW'(b / CHUNK)) work_d[b] = slice_s[b % CHUNK];
        end
        carry_d = slice_cout;
        idx_d   = idx_q + 1'b1;
        // Outputs only change once the whole result is assembled.
        if (last) begin
          out_data_d = work_d;
          out_ovf_d  = ovf_pend_q;
          out_zero_d = ~|work_d;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      work_q     <= '0;
      inv_q      <= 1'b0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      ovf_pend_q <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
      out_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      work_q     <= work_d;
      inv_q      <= inv_d;
      carry_q    <= carry_d;
      idx_q      <= idx_d;
      ovf_pend_q <= ovf_pend_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
      out_zero_q <= out_zero_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_compliment2_chunked.sv
// Bench for compliment2_chunked: a 25/8 instance and a 10/3 instance checked against an
// arithmetic reference model with directed and random operands.
module tb_compliment2_chunked;
  import compliment2_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        drv_valid, drv_ready, sel_b;
  logic [1:0]  in_mode;
  logic [24:0] in_data;

  logic        a_in_ready, a_out_valid, a_out_ovf, a_out_zero;
  logic [24:0] a_out_data;
  logic        b_in_ready, b_out_valid, b_out_ovf, b_out_zero;
  logic [9:0]  b_out_data;

  logic        cur_ready, cur_valid, cur_ovf, cur_zero;
  logic [24:0] cur_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  compliment2_chunked #(.WIDTH(25), .CHUNK(8)) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (drv_valid && !sel_b),
    .in_ready (a_in_ready),
    .in_mode  (in_mode),
    .in_data  (in_data),
    .out_valid(a_out_valid),
    .out_ready(drv_ready && !sel_b),
    .out_data (a_out_data),
    .out_ovf  (a_out_ovf),
    .out_zero (a_out_zero)
  );

  compliment2_chunked #(.WIDTH(10), .CHUNK(3)) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (drv_valid && sel_b),
    .in_ready (b_in_ready),
    .in_mode  (in_mode),
    .in_data  (in_data[9:0]),
    .out_valid(b_out_valid),
    .out_ready(drv_ready && sel_b),
    .out_data (b_out_data),
    .out_ovf  (b_out_ovf),
    .out_zero (b_out_zero)
  );

  assign cur_ready = sel_b ? b_in_ready  : a_in_ready;
  assign cur_valid = sel_b ? b_out_valid : a_out_valid;
  assign cur_ovf   = sel_b ? b_out_ovf   : a_out_ovf;
  assign cur_zero  = sel_b ? b_out_zero  : a_out_zero;
  assign cur_data  = sel_b ? {15'd0, b_out_data} : a_out_data;

  // Reference: results as integers modulo 2**w.
  function automatic void model(input int w, input logic [1:0] mode, input logic [24:0] d,
                                output logic [24:0] r, output logic ovf, output logic zero);
    longint unsigned m    = (64'd1 << w) - 64'd1;
    longint unsigned half = 64'd1 << (w - 1);
    longint unsigned x    = longint'(d) & m;
    longint unsigned mag  = x & (half - 64'd1);
    longint unsigned res;
    bit neg = (x >= half);
    ovf = 1'b0;
    case (mode)
      2'd0: res = x;
      2'd1: begin res = ((m + 64'd1) - x) & m; ovf = (x == half); end
      2'd2: begin res = neg ? (((m + 64'd1) - x) & m) : x; ovf = neg && (x == half); end
      default: res = neg ? (((m + 64'd1) - mag) & m) : mag;
    endcase
    r    = res[24:0];
    zero = (res == 64'd0);
  endfunction

  task automatic run_op(input bit b, input logic [1:0] mode, input logic [24:0] data,
                        input int hold, input logic [24:0] exp_d, input logic exp_ovf,
                        input logic exp_zero);
    int to;
    int lat;
    sel_b = b;
    @(negedge clk);
    to = 0;
    while (!cur_ready && to < 20) begin @(negedge clk); to++; end
    vectors++;
    if (cur_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_before_accept: got %b want 1", cur_ready);
    end
    in_mode = mode; in_data = data; drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    in_mode = 2'($urandom); in_data = 25'($urandom);
    vectors++;
    if (cur_ready !== 1'b0 || cur_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_after_accept: ready %b valid %b want 0 0", cur_ready, cur_valid);
    end
    lat = 0;
    while (!cur_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
      if (!cur_valid) begin in_mode = 2'($urandom); in_data = 25'($urandom); end
    end
    vectors++;
    if (lat !== 4) begin
      miscompares++;
      $display("FAIL latency: got %0d edges want 4", lat);
    end
    vectors++;
    if (cur_data !== exp_d || cur_ovf !== exp_ovf || cur_zero !== exp_zero) begin
      miscompares++;
      $display("FAIL result b=%0d mode=%0d in=%h: got %h ovf %b zero %b want %h ovf %b zero %b",
               b, mode, data, cur_data, cur_ovf, cur_zero, exp_d, exp_ovf, exp_zero);
    end
    if (hold > 0) drv_valid = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (cur_valid !== 1'b1 || cur_ready !== 1'b0 || cur_data !== exp_d ||
          cur_ovf !== exp_ovf || cur_zero !== exp_zero) begin
        miscompares++;
        $display("FAIL hold_cycle%0d: valid %b ready %b data %h ovf %b zero %b want 1 0 %h %b %b",
                 k, cur_valid, cur_ready, cur_data, cur_ovf, cur_zero, exp_d, exp_ovf, exp_zero);
      end
    end
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    @(posedge clk); #1;
    drv_ready = 1'b0;
    vectors++;
    if (cur_valid !== 1'b0 || cur_ready !== 1'b1 || cur_data !== exp_d) begin
      miscompares++;
      $display("FAIL after_consume: valid %b ready %b data %h want 0 1 %h",
               cur_valid, cur_ready, cur_data, exp_d);
    end
  endtask

  task automatic run_model(input bit b, input logic [1:0] mode, input logic [24:0] data,
                           input int hold);
    logic [24:0] r;
    logic ovf, zero;
    model(b ? 10 : 25, mode, data, r, ovf, zero);
    run_op(b, mode, data, hold, r, ovf, zero);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; drv_valid = 1'b0; drv_ready = 1'b0; sel_b = 1'b0;
    in_mode = 2'd0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_data !== 25'd0 ||
        a_out_ovf !== 1'b0 || a_out_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_a: ready %b valid %b data %h ovf %b zero %b want 1 0 0 0 0",
               a_in_ready, a_out_valid, a_out_data, a_out_ovf, a_out_zero);
    end
    vectors++;
    if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_out_data !== 10'd0 ||
        b_out_ovf !== 1'b0 || b_out_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_b: ready %b valid %b data %h ovf %b zero %b want 1 0 0 0 0",
               b_in_ready, b_out_valid, b_out_data, b_out_ovf, b_out_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op(0, MODE_NEG,   25'd1,       0, 25'h1FFFFFF, 1'b0, 1'b0);
    run_op(0, MODE_NEG,   25'h1000000, 0, 25'h1000000, 1'b1, 1'b0);
    run_op(0, MODE_NEG,   25'h0000100, 0, 25'h1FFFF00, 1'b0, 1'b0);
    run_op(0, MODE_NEG,   25'd0,       0, 25'd0,       1'b0, 1'b1);
    run_op(0, MODE_ABS,   25'h1FFFFF6, 0, 25'd10,      1'b0, 1'b0);
    run_op(0, MODE_ABS,   25'd10,      0, 25'd10,      1'b0, 1'b0);
    run_op(0, MODE_ABS,   25'h1000000, 0, 25'h1000000, 1'b1, 1'b0);
    run_op(0, MODE_PASS,  25'h0ABCDEF, 0, 25'h0ABCDEF, 1'b0, 1'b0);
    run_op(0, MODE_SM2TC, 25'h1000005, 0, 25'h1FFFFFB, 1'b0, 1'b0);
    run_op(0, MODE_SM2TC, 25'h1000000, 0, 25'd0,       1'b0, 1'b1);
  endtask

  task automatic test_hold();
    run_op(0, MODE_ABS, 25'h1FFFFF6, 5, 25'd10, 1'b0, 1'b0);
  endtask

  task automatic test_abort_reset();
    sel_b = 1'b0;
    @(negedge clk);
    in_mode = MODE_NEG; in_data = 25'd1; drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_data !== 25'd0) begin
      miscompares++;
      $display("FAIL abort_reset: valid %b ready %b data %h want 0 1 0",
               a_out_valid, a_in_ready, a_out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (a_out_valid !== 1'b0 || a_out_data !== 25'd0) begin
      miscompares++;
      $display("FAIL abort_no_result: valid %b data %h want 0 0", a_out_valid, a_out_data);
    end
  endtask

  task automatic test_partial_chunk();
    run_op(1, MODE_NEG, 25'd1,   0, 25'h3FF, 1'b0, 1'b0);
    run_op(1, MODE_NEG, 25'h200, 1, 25'h200, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      run_model(1, 2'($urandom), 25'($urandom), int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_random();
    logic [24:0] d;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       d = 25'h1000000;
        1:       d = 25'($urandom_range(0, 3));
        default: d = 25'($urandom);
      endcase
      run_model(0, 2'($urandom), d, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_random();
    test_abort_reset();
    test_partial_chunk();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
